// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared definitions for the piano-key sprite path: screen geometry used by
// the renderer and timing generator, the pop/cooldown state encoding, and a
// helper that sizes the frame counter.
package sprite_pkg;

  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    COOL = 2'd2
  } pop_state_t;

  // Width of a down-counter that must hold max(pop, cool, 1) - 1.
  // Never returns 0 so the counter always has at least one bit.
  function automatic int cnt_width(input int pop_frames, input int cool_frames);
    int m;
    m = 1;
    if (pop_frames > m) m = pop_frames;
    if (cool_frames > m) m = cool_frames;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frame_tick.sv
// frame_tick
// Emits a one-cycle pulse when the video timing counts reach a fixed
// (column, line) position. Used as the once-per-frame update strobe.
// Ports:
//   hcount  in  11  current pixel column
//   vcount  in  10  current line
//   tick    out  1  high while (hcount, vcount) == (TICK_H, TICK_V)
module frame_tick
  import sprite_pkg::*;
#(
  parameter int TICK_H = 0,
  parameter int TICK_V = sprite_pkg::SCREEN_H
) (
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        tick
);

  assign tick = (hcount == 11'(TICK_H)) && (vcount == 10'(TICK_V));

endmodule

// File: rtl/sprite_pop_ctrl.sv
// sprite_pop_ctrl
// Per-frame controller for the piano-key sprite. Latches note-hit pulses,
// runs the pop/cooldown sequence and bounces the sprite horizontally. All
// registered outputs update only on the frame tick (first blanking line),
// so the renderer never sees a change mid-frame.
// Ports:
//   pixel_clk_in  in   1  pixel clock
//   rst_n_in      in   1  asynchronous active-low reset
//   hcount_in     in  11  pixel column from timing generator
//   vcount_in     in  10  line from timing generator
//   note_hit_in   in   1  hit pulse, any length, any cycle
//   move_en_in    in   1  enables horizontal motion
//   pop_out       out  1  popped image select (high in POP)
//   x_out         out 11  sprite left column, within [0, SCREEN_W-WIDTH]
//   y_out         out 10  sprite top row (fixed)
//   busy_out      out  1  high in POP or COOL
module sprite_pop_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH       = 256,
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int Y_POS       = 232,
  parameter int POP_FRAMES  = 8,
  parameter int COOL_FRAMES = 4,
  parameter int STEP        = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        note_hit_in,
  input  logic        move_en_in,
  output logic        pop_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        busy_out
);

  localparam int XMAX  = SCREEN_W - WIDTH;
  localparam int CNT_W = cnt_width(POP_FRAMES, COOL_FRAMES);

  localparam logic [CNT_W-1:0] POP_LOAD  = CNT_W'(POP_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOL_FRAMES > 0) ? COOL_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [11:0]      XMAX_12   = 12'(XMAX);
  localparam logic [11:0]      STEP_12   = 12'(STEP);
  localparam logic [10:0]      X_RST     = 11'(XMAX / 2);

  logic             tick;
  pop_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pending, consume, hit_now;
  logic [10:0]      x_q, x_nxt;
  logic             dir_left, dir_nxt;
  logic [11:0]      x_ext, x_sum;

  frame_tick #(
    .TICK_H (0),
    .TICK_V (SCREEN_H)
  ) u_frame_tick (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .tick   (tick)
  );

  // A hit arriving on the tick cycle itself is seen by the FSM that cycle.
  assign hit_now = pending | note_hit_in;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    consume   = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (hit_now) begin
            state_nxt = POP;
            cnt_nxt   = POP_LOAD;
            consume   = 1'b1;
          end
        end
        POP: begin
          if (hit_now) begin
            cnt_nxt = POP_LOAD;
            consume = 1'b1;
          end else if (cnt == '0) begin
            if (COOL_FRAMES == 0) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = COOL;
              cnt_nxt   = COOL_LOAD;
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        COOL: begin
          // Hits are held, not consumed, until back in IDLE.
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // 12-bit arithmetic keeps the clamp compares free of wrap-around.
  assign x_ext = {1'b0, x_q};
  assign x_sum = x_ext + STEP_12;

  always_comb begin
    x_nxt   = x_q;
    dir_nxt = dir_left;
    if (tick && move_en_in) begin
      if (!dir_left) begin
        if (x_sum >= XMAX_12) begin
          x_nxt   = 11'(XMAX);
          dir_nxt = 1'b1;
        end else begin
          x_nxt = x_sum[10:0];
        end
      end else begin
        if (x_ext <= STEP_12) begin
          x_nxt   = '0;
          dir_nxt = 1'b0;
        end else begin
          x_nxt = 11'(x_ext - STEP_12);
        end
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      pop_out  <= 1'b0;
      x_q      <= X_RST;
      dir_left <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // A new hit wins over a same-cycle consume.
      if (note_hit_in)  pending <= 1'b1;
      else if (consume) pending <= 1'b0;
      pop_out  <= (state_nxt == POP);
      x_q      <= x_nxt;
      dir_left <= dir_nxt;
    end
  end

  assign x_out    = x_q;
  assign y_out    = 10'(Y_POS);
  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_sprite_pop_ctrl.sv
module tb_sprite_pop_ctrl;

  typedef struct packed {
    logic        pop;
    logic        busy;
    logic [10:0] x;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount = 11'd1;
  logic [9:0]  vcount = 10'd720;
  logic        note_hit = 1'b0;
  logic        move_en = 1'b0;

  logic        pop4, busy4, pop7, busy7;
  logic [10:0] x4, x7;
  logic [9:0]  y4, y7;

  exp_t        q4[$];
  logic [10:0] q7[$];
  int          errors = 0;
  int          checks = 0;
  string       cur = "init";

  always #5 clk = ~clk;

  sprite_pop_ctrl dut4 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .note_hit_in  (note_hit),
    .move_en_in   (move_en),
    .pop_out      (pop4),
    .x_out        (x4),
    .y_out        (y4),
    .busy_out     (busy4)
  );

  sprite_pop_ctrl #(.STEP(7)) dut7 (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .note_hit_in  (note_hit),
    .move_en_in   (move_en),
    .pop_out      (pop7),
    .x_out        (x7),
    .y_out        (y7),
    .busy_out     (busy7)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached in %s", cur);
    $fatal(1, "watchdog");
  end

  task automatic push4(input logic p, input logic b, input int x, input int n);
    exp_t e;
    e = '{pop: p, busy: b, x: 11'(x)};
    repeat (n) q4.push_back(e);
  endtask

  task automatic cyc(input logic [10:0] h, input logic [9:0] v, input logic hit);
    @(negedge clk);
    hcount   = h;
    vcount   = v;
    note_hit = hit;
  endtask

  // One compressed frame: two active cycles, the tick cycle, then one
  // blanking cycle. Expected values are popped right after the tick edge.
  task automatic frame(input logic hit_active, input logic hit_tick);
    exp_t        e;
    logic [10:0] ex7;
    cyc(11'd100, 10'd50, hit_active);
    cyc(11'd101, 10'd50, 1'b0);
    cyc(11'd0, 10'd720, hit_tick);
    @(negedge clk);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks += 3;
      if (pop4 !== e.pop) begin
        errors++;
        $display("FAIL %s pop: got %b want %b", cur, pop4, e.pop);
      end
      if (busy4 !== e.busy) begin
        errors++;
        $display("FAIL %s busy: got %b want %b", cur, busy4, e.busy);
      end
      if (x4 !== e.x) begin
        errors++;
        $display("FAIL %s x: got %0d want %0d", cur, x4, e.x);
      end
    end
    if (q7.size() > 0) begin
      ex7 = q7.pop_front();
      checks++;
      if (x7 !== ex7) begin
        errors++;
        $display("FAIL %s x_step7: got %0d want %0d", cur, x7, ex7);
      end
    end
    checks++;
    if (y4 !== 10'd232 || y7 !== 10'd232) begin
      errors++;
      $display("FAIL %s y: got %0d/%0d want 232", cur, y4, y7);
    end
    hcount   = 11'd1;
    vcount   = 10'd720;
    note_hit = 1'b0;
  endtask

  task automatic check_drained();
    checks++;
    if (q4.size() != 0 || q7.size() != 0) begin
      errors++;
      $display("FAIL %s drained: got %0d/%0d left want 0/0", cur, q4.size(), q7.size());
    end
  endtask

  task automatic check_reset_vals();
    checks++;
    if (pop4 !== 1'b0 || busy4 !== 1'b0 || x4 !== 11'd512 || y4 !== 10'd232 || x7 !== 11'd512) begin
      errors++;
      $display("FAIL %s reset_vals: got pop=%b busy=%b x=%0d y=%0d x7=%0d want 0 0 512 232 512",
               cur, pop4, busy4, x4, y4, x7);
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    cyc(11'd100, 10'd50, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    push4(1'b0, 1'b0, 512, 2);
    q7.push_back(11'd512);
    q7.push_back(11'd512);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_drained();
  endtask

  task automatic test_single_pop();
    cur = "single_pop";
    push4(1'b1, 1'b1, 512, 8);
    push4(1'b0, 1'b1, 512, 4);
    push4(1'b0, 1'b0, 512, 1);
    for (int i = 1; i <= 13; i++) frame(i == 1, 1'b0);
    check_drained();
  endtask

  task automatic test_retrigger();
    cur = "retrigger";
    push4(1'b1, 1'b1, 512, 13);
    push4(1'b0, 1'b1, 512, 4);
    push4(1'b0, 1'b0, 512, 1);
    for (int i = 1; i <= 18; i++) frame(i == 1 || i == 6, 1'b0);
    check_drained();
  endtask

  task automatic push_double_pop();
    push4(1'b1, 1'b1, 512, 8);
    push4(1'b0, 1'b1, 512, 4);
    push4(1'b0, 1'b0, 512, 1);
    push4(1'b1, 1'b1, 512, 8);
    push4(1'b0, 1'b1, 512, 4);
    push4(1'b0, 1'b0, 512, 1);
  endtask

  task automatic test_cool_hit();
    cur = "cool_hit";
    push_double_pop();
    for (int i = 1; i <= 26; i++) frame(i == 1 || i == 10, 1'b0);
    check_drained();
  endtask

  task automatic test_set_wins();
    cur = "set_wins";
    push_double_pop();
    for (int i = 1; i <= 26; i++) frame(i == 1, i == 13);
    check_drained();
  endtask

  task automatic test_reset_mid_pop();
    cur = "reset_mid_pop";
    push4(1'b1, 1'b1, 512, 3);
    for (int i = 1; i <= 3; i++) frame(i == 1, 1'b0);
    cyc(11'd100, 10'd50, 1'b1);
    cyc(11'd101, 10'd50, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    push4(1'b0, 1'b0, 512, 2);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_drained();
  endtask

  task automatic test_bounce();
    cur = "bounce";
    @(negedge clk);
    rst_n   = 1'b0;
    move_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 128; k++) push4(1'b0, 1'b0, 512 + 4 * k, 1);
    for (int k = 1; k <= 256; k++) push4(1'b0, 1'b0, 1024 - 4 * k, 1);
    push4(1'b0, 1'b0, 4, 1);
    push4(1'b0, 1'b0, 8, 1);
    for (int k = 1; k <= 73; k++) q7.push_back(11'(512 + 7 * k));
    q7.push_back(11'd1024);
    for (int k = 1; k <= 146; k++) q7.push_back(11'(1024 - 7 * k));
    q7.push_back(11'd0);
    q7.push_back(11'd7);
    q7.push_back(11'd14);
    for (int i = 0; i < 386; i++) frame(1'b0, 1'b0);
    check_drained();
    cur = "freeze";
    move_en = 1'b0;
    push4(1'b0, 1'b0, 8, 2);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    move_en = 1'b1;
    push4(1'b0, 1'b0, 12, 1);
    frame(1'b0, 1'b0);
    check_drained();
  endtask

  initial begin
    test_reset();
    test_single_pop();
    test_retrigger();
    test_cool_hit();
    test_set_wins();
    test_reset_mid_pop();
    test_bounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
